// File: rtl/z80_pin_cycle_frontend.sv
// Z80 pin-level bus front end: synchronizes raw strobes, turns each bus cycle into one
// request/response transaction and stretches the CPU with WAIT. Optional timeout: CARBON_Z80_PIN_TIMEOUT_EN.
module z80_pin_cycle_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  FAULT_RDATA    = 8'hFF,
    parameter logic [7:0]  INTACK_VECTOR  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [15:0] z_addr,
    input  logic [7:0]  z_din,
    output logic        z_wait_n,
    output logic [7:0]  z_dout,
    output logic        z_doe,
    output logic        req_valid,
    output logic        req_is_io,
    output logic        req_write,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic        rsp_fault,
    output logic        busy,
    output logic        fault_flag,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  sync1_q, sync2_q;
    logic        mreq, iorq, rd, wr, m1;
    logic        latch_cycle;
    logic        is_io_q, write_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  dout_d;
    logic        doe_d;
    logic        fault_set;
    logic        timeout_set;

    // Strobe order in the synchronizer: {m1, wr, rd, iorq, mreq}; idle level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {m1_n, wr_n, rd_n, iorq_n, mreq_n};
            sync2_q <= sync1_q;
        end
    end

    assign mreq = ~sync2_q[0];
    assign iorq = ~sync2_q[1];
    assign rd   = ~sync2_q[2];
    assign wr   = ~sync2_q[3];
    assign m1   = ~sync2_q[4];

`ifdef CARBON_Z80_PIN_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tcnt_q;
    logic        tcnt_clr, tcnt_inc;
    logic        tcnt_expired;

    assign tcnt_expired = (tcnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst || tcnt_clr) begin
            tcnt_q <= '0;
        end else if (tcnt_inc) begin
            tcnt_q <= tcnt_q + 16'd1;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        latch_cycle = 1'b0;
        dout_d      = z_dout;
        doe_d       = 1'b0;
        fault_set   = 1'b0;
        timeout_set = 1'b0;
`ifdef CARBON_Z80_PIN_TIMEOUT_EN
        tcnt_clr    = 1'b0;
        tcnt_inc    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m1 && iorq) begin
                    state_d = HOLD;
                    dout_d  = INTACK_VECTOR;
                    doe_d   = 1'b1;
                end else if ((mreq || iorq) && (rd || wr)) begin
                    latch_cycle = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d = RSP;
`ifdef CARBON_Z80_PIN_TIMEOUT_EN
                    tcnt_clr = 1'b1;
`endif
                end
            end
            RSP: begin
                if (rsp_valid) begin
                    state_d   = HOLD;
                    dout_d    = rsp_fault ? FAULT_RDATA : rsp_rdata;
                    doe_d     = ~write_q;
                    fault_set = rsp_fault;
                end
`ifdef CARBON_Z80_PIN_TIMEOUT_EN
                else if (tcnt_expired) begin
                    state_d     = HOLD;
                    dout_d      = FAULT_RDATA;
                    doe_d       = ~write_q;
                    timeout_set = 1'b1;
                end else begin
                    tcnt_inc = 1'b1;
                end
`endif
            end
            HOLD: begin
                if (!mreq && !iorq) begin
                    state_d = IDLE;
                end else begin
                    doe_d = z_doe;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            z_wait_n     <= 1'b1;
            z_doe        <= 1'b0;
            z_dout       <= '0;
            fault_flag   <= 1'b0;
            timeout_flag <= 1'b0;
            is_io_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q  <= state_d;
            z_wait_n <= ~((state_d == REQ) || (state_d == RSP));
            z_doe    <= doe_d;
            z_dout   <= dout_d;
            if (fault_set) begin
                fault_flag <= 1'b1;
            end
            if (timeout_set) begin
                timeout_flag <= 1'b1;
            end
            if (latch_cycle) begin
                is_io_q <= iorq;
                write_q <= wr;
                addr_q  <= z_addr;
                wdata_q <= z_din;
            end
        end
    end

    assign req_valid = (state_q == REQ);
    assign req_is_io = is_io_q;
    assign req_write = write_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
